// File: rtl/loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
// Frame layout: 16-bit word count (LE), count x 32-bit LE words, XOR checksum byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam bit LITTLE_ENDIAN  = 1'b1;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int CHK_W          = 8;

  // States in which a frame is in progress and bytes are accepted.
  function automatic logic is_busy(input loader_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; emits a registered
// word_valid pulse with the completed word the cycle after its 4th byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic [BIDX_W-1:0] byte_idx,
  output logic [31:0]       word,
  output logic              word_valid
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        byte_idx <= '0;
        word     <= '0;
      end else if (in_valid) begin
        // Shifting in from the top leaves byte 0 in bits 7:0 after four bytes.
        word       <= {in_byte, word[31:8]};
        byte_idx   <= byte_idx + BIDX_W'(1);
        word_valid <= (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot controller: holds the core in reset, receives a framed image from the
// UART byte stream, writes it to instruction memory and releases the core.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 27_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              core_rst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [16:0]     DEPTH17 = 17'(DEPTH);

  loader_state_t     state, state_nx;
  logic [15:0]       word_cnt;
  logic [15:0]       word_idx;
  logic [15:0]       count_rx;
  logic [CHK_W-1:0]  chk;
  logic [TO_W-1:0]   to_cnt;
  logic [BIDX_W-1:0] byte_idx;
  logic              accept;
  logic              start_go;
  logic              data_byte;
  logic              word_end;
  logic              last_word;
  logic              count_bad;
  logic              timeout_hit;

  assign accept    = rx_valid & rx_ready;
  assign start_go  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign data_byte = accept && (state == ST_DATA);
  assign word_end  = data_byte && (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
  assign last_word = (word_idx == word_cnt - 16'd1);

  // Full count as it will be once the high byte now on rx_data is captured.
  assign count_rx  = {rx_data, word_cnt[7:0]};
  assign count_bad = (count_rx == 16'd0) || ({1'b0, count_rx} > DEPTH17);

  // An accepted byte in the same cycle always wins over the timeout.
  assign timeout_hit = busy && !accept && (to_cnt == TO_LAST);

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start_go) state_nx = ST_CNT_LO;
      ST_CNT_LO: if (accept) state_nx = ST_CNT_HI;
      ST_CNT_HI: if (accept) state_nx = count_bad ? ST_ERR : ST_DATA;
      ST_DATA:   if (word_end && last_word) state_nx = ST_CHK;
      ST_CHK:    if (accept) state_nx = (rx_data == chk) ? ST_DONE : ST_ERR;
      default:   state_nx = ST_IDLE;
    endcase
    if (timeout_hit) state_nx = ST_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      word_idx <= '0;
      chk      <= '0;
      to_cnt   <= '0;
      wr_addr  <= '0;
    end else if (start_go) begin
      word_cnt <= '0;
      word_idx <= '0;
      chk      <= '0;
      to_cnt   <= '0;
    end else begin
      if (accept && (state == ST_CNT_LO)) word_cnt[7:0]  <= rx_data;
      if (accept && (state == ST_CNT_HI)) word_cnt[15:8] <= rx_data;
      if (data_byte) chk <= chk ^ rx_data;
      // Address is registered alongside the packer's word_valid pulse.
      if (word_end) begin
        wr_addr  <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + 16'd1;
      end
      if (accept)    to_cnt <= '0;
      else if (busy) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_go),
    .in_valid   (data_byte),
    .in_byte    (rx_data),
    .byte_idx   (byte_idx),
    .word       (wr_data),
    .word_valid (wr_en)
  );

  assign busy     = is_busy(state);
  assign rx_ready = busy;
  assign core_rst = busy || (state == ST_ERR);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are scored against a byte-level
// model of the frame format (count, LE words, XOR checksum, idle-gap abort).
module tb_imem_loader;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              core_rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .core_rst (core_rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int out_cyc;

  logic [7:0]        tx_bytes[$];
  int                tx_gaps[$];
  int                acc_cyc[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  int                obs_cyc[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic              exp_done;
  logic              exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: walk the byte list as the frame format defines it. A gap of
  // TIMEOUT or more idle cycles before a byte aborts the frame before it.
  task automatic build_expect();
    int n;
    int k;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b1;
    n = 0;
    x = 8'h00;
    w = 32'h0;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      if (tx_gaps[i] >= TIMEOUT) return;
      if (i == 0) n = int'(tx_bytes[i]);
      else if (i == 1) begin
        n = n + 256 * int'(tx_bytes[i]);
        if (n == 0 || n > DEPTH) return;
      end else if (i < 2 + 4 * n) begin
        k = i - 2;
        w = w | (32'(tx_bytes[i]) << (8 * (k % 4)));
        x = x ^ tx_bytes[i];
        if (k % 4 == 3) begin
          exp_addr.push_back(ADDR_W'(k / 4));
          exp_data.push_back(w);
          w = 32'h0;
        end
      end else begin
        exp_done = (tx_bytes[i] == x);
        exp_err  = !exp_done;
        return;
      end
    end
  endtask

  task automatic frame_clear();
    tx_bytes.delete();
    tx_gaps.delete();
  endtask

  task automatic frame_push(input logic [7:0] b, input int g);
    tx_bytes.push_back(b);
    tx_gaps.push_back(g);
  endtask

  task automatic frame_words(input int n, input bit good_chk);
    logic [15:0] n16;
    logic [31:0] w;
    logic [7:0]  x;
    frame_clear();
    n16 = 16'(n);
    x   = 8'h00;
    frame_push(n16[7:0], 0);
    frame_push(n16[15:8], 0);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        frame_push(w[8*b +: 8], 0);
        x = x ^ w[8*b +: 8];
      end
    end
    if (!good_chk) x = x ^ 8'($urandom_range(1, 255));
    frame_push(x, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit st, output bit ok);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = st;
    @(negedge clk);
    ok = rx_ready;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    start    = 1'b0;
    if (ok) acc_cyc.push_back(cyc);
  endtask

  task automatic run_frame(input string tag, input int start_at);
    bit ok;
    int t;
    int a;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    acc_cyc.delete();
    build_expect();
    for (int i = 0; i < tx_bytes.size(); i++) begin
      send_byte(tx_bytes[i], tx_gaps[i], (i == start_at), ok);
      if (!ok) break;
    end
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < TIMEOUT + 20) begin
      @(posedge clk); #1;
      t++;
    end
    out_cyc = cyc;

    total_cnt++;
    if (done !== exp_done) $display("FAIL %s_done: got %b expected %b", tag, done, exp_done);
    else pass_cnt++;
    total_cnt++;
    if (err !== exp_err) $display("FAIL %s_err: got %b expected %b", tag, err, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (core_rst !== exp_err) $display("FAIL %s_core_rst: got %b expected %b", tag, core_rst, exp_err);
    else pass_cnt++;
    total_cnt++;
    if ({rx_ready, busy} !== 2'b00) $display("FAIL %s_idle_flags: got rx_ready/busy=%b expected 00", tag, {rx_ready, busy});
    else pass_cnt++;
    total_cnt++;
    if (obs_addr.size() !== exp_addr.size())
      $display("FAIL %s_write_count: got %0d expected %0d", tag, obs_addr.size(), exp_addr.size());
    else pass_cnt++;

    for (int j = 0; j < obs_addr.size() && j < exp_addr.size(); j++) begin
      total_cnt++;
      if (obs_addr[j] !== exp_addr[j] || obs_data[j] !== exp_data[j])
        $display("FAIL %s_write%0d: got %0h@%0h expected %0h@%0h", tag, j, obs_data[j], obs_addr[j], exp_data[j], exp_addr[j]);
      else pass_cnt++;
      a = 2 + 4 * j + 3;
      total_cnt++;
      if (a >= acc_cyc.size() || obs_cyc[j] !== acc_cyc[a])
        $display("FAIL %s_write%0d_timing: got cycle %0d expected cycle after 4th byte", tag, j, obs_cyc[j]);
      else pass_cnt++;
    end

    if (exp_done) begin
      total_cnt++;
      if (out_cyc !== acc_cyc[acc_cyc.size() - 1])
        $display("FAIL %s_release_latency: got cycle %0d expected %0d", tag, out_cyc, acc_cyc[acc_cyc.size() - 1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({core_rst, rx_ready, wr_en, busy, done, err} !== 6'b0 || wr_addr !== '0 || wr_data !== 32'h0)
      $display("FAIL reset_values: got flags=%b addr=%0h data=%0h expected all zero",
               {core_rst, rx_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total_cnt++;
    if ({core_rst, rx_ready, busy, done, err} !== 5'b0 || obs_addr.size() != 0)
      $display("FAIL reset_idle: got flags=%b writes=%0d expected all zero",
               {core_rst, rx_ready, busy, done, err}, obs_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    do_start();
    total_cnt++;
    if ({core_rst, rx_ready, busy, done, err} !== 5'b11100)
      $display("FAIL start_flags: got %b expected 11100", {core_rst, rx_ready, busy, done, err});
    else pass_cnt++;
    frame_clear();
    frame_push(8'h02, 0); frame_push(8'h00, 0);
    frame_push(8'h13, 0); frame_push(8'h00, 0); frame_push(8'h00, 0); frame_push(8'h00, 0);
    frame_push(8'h6F, 0); frame_push(8'h00, 0); frame_push(8'h00, 0); frame_push(8'h00, 0);
    frame_push(8'h7C, 0);
    run_frame("basic", -1);
    total_cnt++;
    if (obs_data.size() != 2 || obs_data[0] !== 32'h13 || obs_data[1] !== 32'h6F)
      $display("FAIL basic_words: got %0d writes expected 00000013,0000006F", obs_data.size());
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    do_start();
    tx_bytes[10] = 8'h00;
    run_frame("badchk", -1);
    do_start();
    total_cnt++;
    if ({core_rst, rx_ready, done, err} !== 4'b1100)
      $display("FAIL restart_clears_err: got %b expected 1100", {core_rst, rx_ready, done, err});
    else pass_cnt++;
    frame_words(3, 1'b1);
    run_frame("restart", -1);
  endtask

  task automatic test_bad_count();
    do_start();
    frame_clear();
    frame_push(8'h00, 0); frame_push(8'h00, 0);
    run_frame("cnt_zero", -1);
    total_cnt++;
    if (out_cyc !== acc_cyc[acc_cyc.size() - 1])
      $display("FAIL cnt_zero_latency: got cycle %0d expected %0d", out_cyc, acc_cyc[acc_cyc.size() - 1]);
    else pass_cnt++;
    do_start();
    frame_clear();
    frame_push(8'h01, 0); frame_push(8'h08, 0);
    frame_push(8'hAA, 0); frame_push(8'hBB, 0); frame_push(8'hCC, 0); frame_push(8'hDD, 0);
    run_frame("cnt_big", -1);
  endtask

  task automatic test_timeout();
    do_start();
    frame_clear();
    frame_push(8'h02, 0); frame_push(8'h00, 0); frame_push(8'h11, 0); frame_push(8'h22, 0);
    run_frame("stall", -1);
    total_cnt++;
    if (acc_cyc.size() != 4 || out_cyc - acc_cyc[acc_cyc.size() - 1] !== TIMEOUT)
      $display("FAIL stall_timing: got %0d idle cycles expected %0d", out_cyc - acc_cyc[acc_cyc.size() - 1], TIMEOUT);
    else pass_cnt++;
    do_start();
    frame_words(2, 1'b1);
    tx_gaps[4]  = TIMEOUT - 2;
    tx_gaps[8]  = TIMEOUT - 1;
    tx_gaps[10] = TIMEOUT - 1;
    run_frame("alive", -1);
    do_start();
    frame_words(2, 1'b1);
    tx_gaps[7] = TIMEOUT;
    run_frame("abort", -1);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_start();
    frame_words(3, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(tx_bytes[i], 0, 1'b0, ok);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({core_rst, rx_ready, wr_en, busy, done, err} !== 6'b0 || wr_addr !== '0 || wr_data !== 32'h0)
      $display("FAIL midrst_values: got flags=%b addr=%0h data=%0h expected all zero",
               {core_rst, rx_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({core_rst, busy, done, err} !== 4'b0)
      $display("FAIL midrst_after: got %b expected 0000", {core_rst, busy, done, err});
    else pass_cnt++;
    do_start();
    frame_words(2, 1'b1);
    run_frame("after_rst", -1);
  endtask

  task automatic test_full_depth();
    int bad;
    do_start();
    frame_words(DEPTH, 1'b1);
    run_frame("full", -1);
    total_cnt++;
    if (obs_addr.size() == 0 || obs_addr[obs_addr.size() - 1] !== {ADDR_W{1'b1}})
      $display("FAIL full_last_addr: got %0d writes expected last addr %0h", obs_addr.size(), {ADDR_W{1'b1}});
    else pass_cnt++;
    bad = 0;
    for (int j = 1; j < obs_cyc.size(); j++)
      if (obs_cyc[j] - obs_cyc[j - 1] != 4) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL full_spacing: got %0d irregular gaps expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_random_frames();
    int n;
    int st;
    bit good;
    bit to;
    for (int f = 0; f < 10; f++) begin
      do_start();
      n    = $urandom_range(1, 12);
      good = ($urandom_range(0, 3) != 0);
      frame_words(n, good);
      for (int i = 0; i < tx_gaps.size(); i++) tx_gaps[i] = $urandom_range(0, 2);
      to = ($urandom_range(0, 4) == 0);
      st = -1;
      if (to) tx_gaps[$urandom_range(2, tx_gaps.size() - 1)] = TIMEOUT + $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 1) st = $urandom_range(2, tx_bytes.size() - 1);
      run_frame($sformatf("rand%0d", f), st);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_bad_count();
    test_timeout();
    test_reset_mid_frame();
    test_full_depth();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot/program controller sequencing the core's instruction memory from a byte stream (UART receiver). On `start` it holds the core in reset and accepts a framed image: 16-bit word count, little-endian 32-bit words, and an XOR checksum byte. It writes each word into instruction memory through a write port alongside the core's `imem_addr`/`imem_data` read port, then releases the core. Sits between the UART RX block, the instruction RAM write port and the core reset input.

## Interface
- `ADDR_W`, 11, instruction-memory word-address width (matches the core's 11-bit `imem_addr`); capacity `2**ADDR_W` words.
- `TIMEOUT`, 27_000_000, idle cycles allowed between accepted bytes inside a frame before abort.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; transfer occurs when `rx_valid & rx_ready`.
- `core_rst`  out  1  reset to core, high while loading or after error.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  word address of the write.
- `wr_data`  out  32  word to write.
- `busy`  out  1  frame in progress.
- `done`  out  1  sticky, last load completed with good checksum.
- `err`  out  1  sticky, last load failed (bad count, checksum, or timeout).

## Operation
- States: IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR.
- IDLE: `core_rst=0`, `rx_ready=0`. `start` moves to CNT_LO, clears `done`/`err`, sets `core_rst=1`, and clears the word counter, byte index, checksum and timeout counter.
- CNT_LO/CNT_HI: accepted bytes form count N (low byte first). After CNT_HI, N==0 or N>2**ADDR_W goes to ERR; otherwise the FSM goes to DATA.
- DATA: bytes pack little-endian (byte 0 → bits 7:0). Each data byte is XORed into an 8-bit checksum. The 4th byte of a word triggers the write. After word N-1 is written, the FSM goes to CHK.
- CHK: one byte is accepted. If it equals the checksum, the FSM goes to DONE (`done=1`, `core_rst=0`). Otherwise it goes to ERR (`err=1`, `core_rst` stays 1).
- DONE behaves as IDLE with `done` held. ERR holds `core_rst=1` and `rx_ready=0` until `start`.
- `rx_ready=1` exactly in CNT_LO, CNT_HI, DATA and CHK. `busy` is high in the same states.
- Timeout counter: resets on each accepted byte and increments every cycle in a `busy` state. Reaching TIMEOUT-1 goes to ERR.
- `start` while `busy` is ignored.
- Reset values: state IDLE; `core_rst=0`, `rx_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`, `err=0`. After reset the core runs whatever image memory holds.
- Reset mid-frame aborts immediately with the values above; partially written memory is not restored.

## Timing
- `wr_en`, `wr_addr` and `wr_data` are registered. They are high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- `wr_addr` equals the word index, 0..N-1, with no wrap (N is bounded by the count check).
- Throughput is one byte per cycle; back-to-back `rx_valid` is accepted without bubbles.
- State transitions take effect the cycle after the accepting handshake.
- `core_rst` deasserts the cycle after the checksum byte is accepted. The last `wr_en` pulse has by then already completed, at least one cycle earlier.
- Timeout and a byte arriving in the same cycle: the byte wins and the counter resets.
- Checksum mismatch and timeout both end in ERR; there is no separate error code.

## Structure
- Package `loader_pkg`: state enum `loader_state_t`, frame constants (header length 2 bytes, 4 bytes per word, little-endian), and the checksum width.
- Sub-module `byte_packer`: 2-bit byte index plus 32-bit shift/assemble register with a `word_valid` pulse and synchronous clear. The FSM, counters, timeout logic and write port stay in `imem_loader`.

## Test plan
- Reset, then `start`, then frame 02 00, 13 00 00 00, 6F 00 00 00, checksum 7C → `wr_en` pulses at addr 0 (0x00000013) and addr 1 (0x0000006F); `done=1`, `err=0`, `core_rst` low the cycle after 7C.
- Same frame with checksum 00 → ERR: `err=1`, `core_rst` stays 1, `rx_ready=0`. A new `start` then clears `err`.
- Count 00 00, and count `2**ADDR_W+1` → ERR after CNT_HI with no `wr_en` pulse.
- TIMEOUT=16 and the frame stalls after 2 data bytes for 16 cycles → ERR. A byte arriving on cycle 15 instead keeps the frame alive.
- Assert `rst` mid-DATA → next cycle all outputs at reset values and `core_rst=0`. A new `start` loads correctly from addr 0.
- Full-depth load of `2**ADDR_W` words with random data and continuous `rx_valid` → one write per 4 cycles, last `wr_addr` is all ones, checksum matches, `done=1`.
